// File: rtl/au_updn_cnt.sv
// Up/down counter with clear, load, terminal count and sticky wrap flag; one-cycle update latency.
// AU_UPDN_CNT_SAT_EN: when defined, an enabled step at the terminal count holds q instead of wrapping.
// No backpressure: every enabled edge performs its operation; tc is combinational.

module AU_incdec #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             inc_dec,
    output logic [WIDTH-1:0] y
);
    generate
        if (ARCH == 0) begin : g_arch_behav
            assign y = inc_dec ? (a - WIDTH'(1)) : (a + WIDTH'(1));
        end else if (ARCH == 1) begin : g_arch_addconst
            // Decrement is the same adder with an all-ones operand (-1 in two's complement).
            logic [WIDTH-1:0] step;
            assign step = inc_dec ? {WIDTH{1'b1}} : WIDTH'(1);
            assign y    = a + step;
        end else begin : g_arch_toggle
            logic carry;
            always_comb begin
                y     = '0;
                carry = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    y[i]  = a[i] ^ carry;
                    carry = carry & (a[i] ^ inc_dec);
                end
            end
        end
    endgenerate
endmodule

module au_updn_cnt #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             inc_dec,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);
    generate
        if ((WIDTH < 1) || (ARCH < 0) || (ARCH > 2)) begin : g_param_err
            $error("au_updn_cnt: illegal parameters WIDTH=%0d ARCH=%0d", WIDTH, ARCH);
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] step_res;

    AU_incdec #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_incdec (
        .a       (q_q),
        .inc_dec (inc_dec),
        .y       (step_res)
    );

    // tc flags the step boundary only, so clr/ld do not mask it.
    assign tc = en & (inc_dec ? (q_q == '0) : (q_q == {WIDTH{1'b1}}));

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (ld) begin
            q_d   = d;
            ovf_d = 1'b0;
        end else if (en) begin
            if (tc) begin
                ovf_d = 1'b1;
            end
`ifdef AU_UPDN_CNT_SAT_EN
            q_d = tc ? q_q : step_res;
`else
            q_d = step_res;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_au_updn_cnt.sv
// Bench for au_updn_cnt: WIDTH=4 with ARCH 0,1,2 driven in parallel, checked against a queued reference model.
module tb_au_updn_cnt;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, ld, en, inc_dec;
    logic [3:0] d;
    logic [3:0] q_w   [NDUT];
    logic       tc_w  [NDUT];
    logic       ovf_w [NDUT];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            au_updn_cnt #(
                .WIDTH (4),
                .ARCH  (g)
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .ld      (ld),
                .d       (d),
                .en      (en),
                .inc_dec (inc_dec),
                .q       (q_w[g]),
                .tc      (tc_w[g]),
                .ovf     (ovf_w[g])
            );
        end
    endgenerate

`ifdef AU_UPDN_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mq;
    logic       movf;
    int         n_chk  = 0;
    int         n_fail = 0;

    // One clocked operation: tc checked before the edge, q/ovf after it via the scoreboard.
    task automatic step(input logic c, input logic l, input logic e, input logic dir, input logic [3:0] dv);
        logic etc;
        exp_t ex;
        @(negedge clk);
        clr = c; ld = l; en = e; inc_dec = dir; d = dv;
        #1;
        etc = e & (dir ? (mq == 4'h0) : (mq == 4'hF));
        for (int i = 0; i < NDUT; i++) begin
            n_chk++;
            if (tc_w[i] !== etc) begin
                n_fail++;
                $display("FAIL tc arch%0d: got %b expected %b (q=%h)", i, tc_w[i], etc, mq);
            end
        end
        if (c) begin
            mq = 4'h0; movf = 1'b0;
        end else if (l) begin
            mq = dv; movf = 1'b0;
        end else if (e) begin
            if (etc) movf = 1'b1;
            if (!(SAT && etc)) mq = dir ? mq - 4'h1 : mq + 4'h1;
        end
        sb.push_back('{q: mq, ovf: movf});
        @(posedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
        end else begin
            ex = sb.pop_front();
            for (int i = 0; i < NDUT; i++) begin
                n_chk++;
                if (q_w[i] !== ex.q || ovf_w[i] !== ex.ovf) begin
                    n_fail++;
                    $display("FAIL q/ovf arch%0d: got q=%h ovf=%b expected q=%h ovf=%b",
                             i, q_w[i], ovf_w[i], ex.q, ex.ovf);
                end
            end
        end
    endtask

    task automatic check_const(input string name, input logic [3:0] eq, input logic eovf);
        for (int i = 0; i < NDUT; i++) begin
            n_chk++;
            if (q_w[i] !== eq || ovf_w[i] !== eovf) begin
                n_fail++;
                $display("FAIL %s arch%0d: got q=%h ovf=%b expected q=%h ovf=%b",
                         name, i, q_w[i], ovf_w[i], eq, eovf);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 0; ld = 0; en = 0; inc_dec = 0; d = 4'h0;
        mq = 4'h0; movf = 1'b0;
        #3;
        check_const("reset_init", 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Build up ovf=1 and q=9 without passing through clr/ld afterwards.
        step(0, 1, 0, 0, 4'hE);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 1, 0, 4'h0);
        for (int k = 0; k < 16 && mq != 4'h9; k++)
            step(0, 0, 1, (mq > 4'h9), 4'h0);
        check_const("reset_pre", 4'h9, 1'b1);
        #2;
        en = 1'b1; inc_dec = 1'b1;
        rst_n = 1'b0;
        #1;
        check_const("reset_async", 4'h0, 1'b0);
        for (int i = 0; i < NDUT; i++) begin
            n_chk++;
            if (tc_w[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_tc arch%0d: got %b expected 1", i, tc_w[i]);
            end
        end
        @(posedge clk);
        #1;
        check_const("reset_hold", 4'h0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        mq = 4'h0; movf = 1'b0;
        step(0, 0, 1, 0, 4'h0);
        check_const("reset_release", 4'h1, 1'b0);
    endtask

    task automatic test_up_wrap();
        step(0, 1, 1, 0, 4'hE);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 1, 0, 4'h0);
        check_const("up_wrap_end", SAT ? 4'hF : 4'h1, 1'b1);
    endtask

    task automatic test_down_wrap();
        step(1, 0, 0, 0, 4'h0);
        step(0, 0, 1, 1, 4'h0);
        check_const("down_wrap_end", SAT ? 4'h0 : 4'hF, 1'b1);
    endtask

    task automatic test_priority();
        step(0, 0, 1, 0, 4'h0);
        step(1, 1, 1, 0, 4'h7);
        check_const("prio_clr", 4'h0, 1'b0);
        step(0, 1, 1, 0, 4'h7);
        check_const("prio_ld", 4'h7, 1'b0);
    endtask

    task automatic test_hold_dir();
        step(0, 1, 0, 0, 4'h5);
        for (int k = 0; k < 4; k++) step(0, 0, 0, k[0], 4'hA);
        check_const("hold", 4'h5, 1'b0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, k[0], 4'h0);
        check_const("dir_alt", 4'h5, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10000; k++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority();
        test_hold_dir();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
